// File: rtl/stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_sequencer                                              |
// | Description : Moves frames through a chain of NUM_STAGES processing stages |
// |               with inter-stage backpressure, a per-stage watchdog, sticky  |
// |               error capture, abort and a completed-frame counter.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stage_sequencer #(
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 64,
    parameter int TMR_W      = 8,
    parameter int IDX_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_enable,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  frame_done,
    output logic                  busy,
    input  logic                  abort,
    output logic                  error,
    output logic [IDX_W-1:0]      error_stage,
    input  logic                  clear_err,
    output logic [CNT_W-1:0]      frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } stage_state_t;

    localparam int               C_LAST     = NUM_STAGES - 1;
    localparam bit               C_WDOG_EN  = (TIMEOUT != 0);
    // Last legal ACTIVE cycle count; unused when the watchdog is disabled.
    localparam logic [TMR_W-1:0] C_TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    stage_state_t           r_state     [NUM_STAGES];
    logic [TMR_W-1:0]       r_timer     [NUM_STAGES];
    stage_state_t           w_state_nxt [NUM_STAGES];
    logic [TMR_W-1:0]       w_timer_nxt [NUM_STAGES];

    logic                   w_accept;
    logic [NUM_STAGES-1:0]  w_down_free;
    logic [NUM_STAGES-1:0]  w_handoff;
    logic [NUM_STAGES-1:0]  w_enter;
    logic [NUM_STAGES-1:0]  w_err_hit;
    logic [IDX_W-1:0]       w_err_idx;
    logic                   w_error_nxt;
    logic [IDX_W-1:0]       w_error_stage_nxt;
    logic                   w_frame_done_nxt;
    logic [NUM_STAGES-1:0]  w_enable_nxt;
    logic [NUM_STAGES-1:0]  w_start_nxt;
    logic                   w_busy_nxt;

    // Stage 0 takes a new frame only when empty and no error is pending.
    assign in_ready = (r_state[0] == ST_IDLE) && !error;

    // Next-state logic for every stage plus the registered output values.
    always_comb begin
        w_accept = in_valid && in_ready;

        // The last stage drains to the output and never stalls.
        w_down_free = '1;
        for (int i = 0; i < C_LAST; i++) begin
            w_down_free[i] = (r_state[i+1] == ST_IDLE);
        end

        for (int i = 0; i < NUM_STAGES; i++) begin
            w_handoff[i] = !error && (r_state[i] == ST_DONE) && w_down_free[i];
        end

        w_enter[0] = w_accept;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_enter[i] = w_handoff[i-1];
        end

        w_err_hit = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            // An active error freezes every stage, timers included.
            if (!error) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_enter[i]) begin
                            w_state_nxt[i] = ST_ACTIVE;
                            w_timer_nxt[i] = '0;
                        end
                    end
                    ST_ACTIVE: begin
                        // Completion beats a coincident timeout.
                        if (stage_done[i]) begin
                            w_state_nxt[i] = ST_DONE;
                            w_timer_nxt[i] = '0;
                        end else if (C_WDOG_EN && (r_timer[i] == C_TMR_LAST)) begin
                            w_state_nxt[i] = ST_ERR;
                            w_err_hit[i]   = 1'b1;
                        end else begin
                            w_timer_nxt[i] = r_timer[i] + TMR_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (w_handoff[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Lowest stage wins when several time out together.
        w_err_idx = '0;
        for (int i = C_LAST; i >= 0; i--) begin
            if (w_err_hit[i]) begin
                w_err_idx = IDX_W'(i);
            end
        end

        w_error_nxt       = error;
        w_error_stage_nxt = error_stage;
        w_frame_done_nxt  = w_handoff[C_LAST];

        if (clear_err || abort) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                w_state_nxt[i] = ST_IDLE;
                w_timer_nxt[i] = '0;
            end
            w_frame_done_nxt = 1'b0;
        end

        if (clear_err) begin
            w_error_nxt       = 1'b0;
            w_error_stage_nxt = '0;
        end else if (!abort && !error && (|w_err_hit)) begin
            w_error_nxt       = 1'b1;
            w_error_stage_nxt = w_err_idx;
        end

        w_busy_nxt = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_enable_nxt[i] = (w_state_nxt[i] == ST_ACTIVE) && !w_error_nxt;
            w_start_nxt[i]  = (w_state_nxt[i] == ST_ACTIVE) && (r_state[i] != ST_ACTIVE);
            w_busy_nxt      = w_busy_nxt | (w_state_nxt[i] != ST_IDLE);
        end
    end

    // Stage state, timers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_state[i] <= ST_IDLE;
                r_timer[i] <= '0;
            end
            stage_enable <= '0;
            stage_start  <= '0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            error_stage  <= '0;
            frame_count  <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            stage_enable <= w_enable_nxt;
            stage_start  <= w_start_nxt;
            frame_done   <= w_frame_done_nxt;
            busy         <= w_busy_nxt;
            error        <= w_error_nxt;
            error_stage  <= w_error_stage_nxt;
            frame_count  <= frame_count + CNT_W'(w_frame_done_nxt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stage_sequencer                                           |
// | Description : Directed self-checking bench for stage_sequencer: a 3-stage  |
// |               instance with an 8-cycle watchdog and a 2-stage instance     |
// |               with the watchdog disabled and a 4-bit frame counter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, abort, clear_err;
    logic [2:0] stage_done;
    logic       in_ready, frame_done, busy, error;
    logic [2:0] stage_enable, stage_start, error_stage;
    logic [15:0] frame_count;

    logic       b_in_valid, b_abort, b_clear_err;
    logic [1:0] b_stage_done;
    logic       b_in_ready, b_frame_done, b_busy, b_error;
    logic [1:0] b_stage_enable, b_stage_start;
    logic [2:0] b_error_stage;
    logic [3:0] b_frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt [3];
    int fd_cnt;

    always #5 clk = ~clk;

    stage_sequencer #(.NUM_STAGES(3), .TIMEOUT(8), .TMR_W(8), .IDX_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .stage_done(stage_done), .stage_enable(stage_enable), .stage_start(stage_start),
        .frame_done(frame_done), .busy(busy), .abort(abort), .error(error),
        .error_stage(error_stage), .clear_err(clear_err), .frame_count(frame_count)
    );

    stage_sequencer #(.NUM_STAGES(2), .TIMEOUT(0), .TMR_W(8), .IDX_W(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .stage_done(b_stage_done), .stage_enable(b_stage_enable), .stage_start(b_stage_start),
        .frame_done(b_frame_done), .busy(b_busy), .abort(b_abort), .error(b_error),
        .error_stage(b_error_stage), .clear_err(b_clear_err), .frame_count(b_frame_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (stage_start[i]) start_cnt[i]++;
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 3; i++) start_cnt[i] = 0;
        fd_cnt = 0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && busy; k++) step();
        check_eq(tag, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc, bfd, saw_err;
        reset_n = 1'b0; in_valid = 1'b0; abort = 1'b0; clear_err = 1'b0; stage_done = '0;
        b_in_valid = 1'b0; b_abort = 1'b0; b_clear_err = 1'b0; b_stage_done = '0;
        clr_counts();
        step(); step();
        check_eq("rst_enable", stage_enable, 0);
        check_eq("rst_start", stage_start, 0);
        check_eq("rst_busy_fd_err", {busy, frame_done, error}, 0);
        check_eq("rst_err_stage", error_stage, 0);
        check_eq("rst_count", frame_count, 0);
        reset_n = 1'b1;
        check_eq("rst_in_ready", in_ready, 1);
        repeat (3) step();
        check_eq("idle_quiet", {busy, stage_enable, stage_start, frame_done}, 0);

        // Single frame, done on first ACTIVE cycle of each stage.
        clr_counts();
        stage_done = 3'b111; in_valid = 1'b1;
        step();                                        // c1
        check_eq("sf_start_c1", stage_start, 3'b001);
        check_eq("sf_en_c1", stage_enable, 3'b001);
        in_valid = 1'b0;
        step();                                        // c2
        check_eq("sf_start_c2", {busy, stage_start}, 4'b1000);
        step();                                        // c3
        check_eq("sf_start_c3", stage_start, 3'b010);
        step(); step();                                // c5
        check_eq("sf_start_c5", stage_start, 3'b100);
        step();                                        // c6
        check_eq("sf_fd_c6", {frame_done, stage_enable}, 4'b0000);
        step();                                        // c7
        check_eq("sf_fd_c7", frame_done, 1);
        check_eq("sf_count", frame_count, 1);
        check_eq("sf_busy_c7", busy, 0);
        step();
        check_eq("sf_fd_c8", frame_done, 0);

        // Backpressure: last stage held busy while three frames enter.
        clr_counts();
        stage_done = 3'b011; in_valid = 1'b1;
        repeat (7) step();                             // c7
        in_valid = 1'b0;
        step(); step();                                // c9
        check_eq("bp_en_c9", stage_enable, 3'b100);
        check_eq("bp_ready_c9", in_ready, 0);
        step(); step();                                // c11
        check_eq("bp_hold_c11", {busy, stage_enable, in_ready}, 5'b1_100_0);
        check_eq("bp_count_hold", frame_count, 1);
        stage_done = 3'b111;
        step();                                        // c12
        check_eq("bp_c12", {frame_done, stage_enable}, 4'b0000);
        step();                                        // c13
        check_eq("bp_fd_c13", frame_done, 1);
        drain("bp_drain");
        check_eq("bp_starts", {start_cnt[2][7:0], start_cnt[1][7:0], start_cnt[0][7:0]}, 24'h030303);
        check_eq("bp_fd_cnt", fd_cnt, 3);
        check_eq("bp_count", frame_count, 4);

        // Watchdog on stage 1.
        clr_counts();
        stage_done = 3'b001; in_valid = 1'b1;
        step(); in_valid = 1'b0;                       // c1
        step(); step();                                // c3
        check_eq("wd_start_c3", stage_start, 3'b010);
        repeat (7) step();                             // c10
        check_eq("wd_c10", {error, stage_enable}, 4'b0010);
        step();                                        // c11
        check_eq("wd_error", error, 1);
        check_eq("wd_err_stage", error_stage, 1);
        check_eq("wd_en_ready", {stage_enable, in_ready}, 4'b0000);
        in_valid = 1'b1;
        step();                                        // c12
        check_eq("wd_frozen", {busy, error, stage_enable, stage_start}, 8'b1100_0000);
        in_valid = 1'b0; clear_err = 1'b1;
        step();                                        // c13
        clear_err = 1'b0;
        check_eq("wd_clear", {busy, error, error_stage}, 0);
        check_eq("wd_count_kept", frame_count, 4);

        // Done coinciding with the last legal watchdog cycle.
        stage_done = 3'b110; in_valid = 1'b1;
        step(); in_valid = 1'b0;                       // c1
        repeat (7) step();                             // c8
        check_eq("dt_c8", {error, stage_enable}, 4'b0001);
        stage_done = 3'b111;
        step();                                        // c9
        check_eq("dt_c9", {busy, error, stage_enable}, 5'b10000);
        step();
        check_eq("dt_start_c10", stage_start, 3'b010);
        drain("dt_drain");
        check_eq("dt_final", {error, frame_count}, 17'd5);

        // Abort with stages 0 and 2 active.
        stage_done = 3'b010; in_valid = 1'b1;
        step(); stage_done = 3'b011;                   // c1
        step(); stage_done = 3'b010;                   // c2
        step(); step();                                // c4
        in_valid = 1'b0;
        check_eq("ab_c4", {stage_start, stage_enable}, 6'b001_001);
        step();                                        // c5
        check_eq("ab_c5", {stage_start, stage_enable}, 6'b100_101);
        abort = 1'b1;
        step();                                        // c6
        abort = 1'b0;
        check_eq("ab_idle", {busy, stage_enable, stage_start, error}, 0);
        check_eq("ab_count", frame_count, 5);

        // Reset mid-frame.
        stage_done = 3'b000; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check_eq("rm_active", {busy, stage_enable, frame_count}, {1'b1, 3'b001, 16'd5});
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("rm_reset", {busy, stage_enable, stage_start, frame_done, error, frame_count}, 0);
        check_eq("rm_ready", in_ready, 1);

        // Counter wrap on the 4-bit instance.
        b_stage_done = 2'b11; acc = 0; bfd = 0;
        for (int k = 0; k < 200 && (acc < 17 || b_busy); k++) begin
            b_in_valid = (acc < 17);
            if (b_in_valid && b_in_ready) acc++;
            @(posedge clk); #1;
            if (b_frame_done) bfd++;
        end
        b_in_valid = 1'b0;
        check_eq("wr_fd_cnt", bfd, 17);
        check_eq("wr_count", b_frame_count, 1);

        // Disabled watchdog: stage held ACTIVE for 300 cycles.
        b_stage_done = 2'b00; b_in_valid = 1'b1; saw_err = 0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (b_error) saw_err = 1;
        end
        check_eq("nw_no_error", saw_err, 0);
        check_eq("nw_enable", {b_busy, b_stage_enable}, 3'b101);
        b_stage_done = 2'b11;
        for (int k = 0; k < 20 && b_busy; k++) begin
            @(posedge clk); #1;
        end
        check_eq("nw_final", {b_busy, b_error, b_frame_count}, 6'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
